// File: rtl/fsk_tx_modulator.sv
// MSK/FSK transmit modulator: serialises bytes LSB-first into 4-bit signed I/Q
// from a 64-step phase accumulator. BLE 16 smp/bit, 802.15.4 8 smp/chip.
// Ports: clk, rst (sync, active-high); select, chan_idx, tx_data/valid/last in;
// tx_ready, I_out, Q_out, tx_on, bit_strobe, underrun out.
// Optional macro DATA_WHITEN_EN: BLE data whitening from a chan_idx-seeded LFSR.
module fsk_tx_modulator #(
  parameter int TAIL_SYMBOLS = 4,
  parameter int PHASE_BITS   = 6,
  parameter int AMP          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        select,
  input  logic [5:0]        chan_idx,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic signed [3:0] I_out,
  output logic signed [3:0] Q_out,
  output logic              tx_on,
  output logic              bit_strobe,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  localparam int TW = $clog2(TAIL_SYMBOLS * 16 + 1);

  state_t                  state_q, state_d;
  logic [PHASE_BITS-1:0]   phase_q, phase_d;
  logic [3:0]              smp_q, smp_d;
  logic [2:0]              bit_q, bit_d;
  logic [7:0]              byte_q, byte_d;
  logic                    last_q, last_d;
  logic                    sel_q, sel_d;
  logic [TW-1:0]           tail_q, tail_d;
  logic signed [3:0]       i_q, i_d;
  logic signed [3:0]       q_q, q_d;
  logic [6:0]              lfsr_q, lfsr_d;

  logic [3:0]              spb_m1;
  logic [TW-1:0]           tail_m1;
  logic [PHASE_BITS-1:0]   stp;
  logic                    wbit;
  logic                    cur_bit;

  assign spb_m1  = sel_q ? 4'd7 : 4'd15;
  assign tail_m1 = TW'(TAIL_SYMBOLS * (sel_q ? 8 : 16) - 1);
  assign stp     = sel_q ? PHASE_BITS'(2) : PHASE_BITS'(1);

`ifdef DATA_WHITEN_EN
  // 802.15.4 chips are never whitened
  assign wbit = lfsr_q[6] & ~sel_q;
`else
  logic unused_chan;
  assign unused_chan = ^{chan_idx, lfsr_q};
  assign wbit = 1'b0;
`endif

  assign cur_bit    = byte_q[bit_q] ^ wbit;
  assign tx_on      = (state_q != IDLE);
  assign bit_strobe = (state_q == SHIFT) && (smp_q == 4'd0);

  // Quarter-wave cosine magnitude, cos scaled by 1000 and rounded
  function automatic logic signed [3:0] qmag(input logic [4:0] k);
    int c;
    case (k)
      5'd0:    c = 1000;
      5'd1:    c = 995;
      5'd2:    c = 981;
      5'd3:    c = 957;
      5'd4:    c = 924;
      5'd5:    c = 882;
      5'd6:    c = 831;
      5'd7:    c = 773;
      5'd8:    c = 707;
      5'd9:    c = 634;
      5'd10:   c = 556;
      5'd11:   c = 471;
      5'd12:   c = 383;
      5'd13:   c = 290;
      5'd14:   c = 195;
      5'd15:   c = 98;
      default: c = 0;
    endcase
    return 4'((AMP * c + 500) / 1000);
  endfunction

  logic [1:0]        quad;
  logic [3:0]        kidx;
  logic signed [3:0] cm, sm, lut_i, lut_q;

  assign quad = phase_q[PHASE_BITS-1 -: 2];
  assign kidx = phase_q[3:0];
  assign cm   = qmag({1'b0, kidx});
  assign sm   = qmag(5'd16 - {1'b0, kidx});

  always_comb begin
    lut_i = cm;
    lut_q = sm;
    unique case (quad)
      2'd0: begin lut_i = cm;  lut_q = sm;  end
      2'd1: begin lut_i = -sm; lut_q = cm;  end
      2'd2: begin lut_i = -cm; lut_q = -sm; end
      2'd3: begin lut_i = sm;  lut_q = -cm; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    smp_d    = smp_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    last_d   = last_q;
    sel_d    = sel_q;
    tail_d   = tail_q;
    lfsr_d   = lfsr_q;
    tx_ready = 1'b0;
    underrun = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          byte_d  = tx_data;
          last_d  = tx_last;
          sel_d   = (select == 2'd1);
          lfsr_d  = {1'b1, chan_idx};
          phase_d = '0;
          smp_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        phase_d = cur_bit ? phase_q + stp : phase_q - stp;
        if (smp_q == spb_m1) begin
          smp_d  = '0;
          bit_d  = bit_q + 3'd1;
          lfsr_d = {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ lfsr_q[6],
                    lfsr_q[2], lfsr_q[1], lfsr_q[0], lfsr_q[6]};
          if (bit_q == 3'd7) begin
            tx_ready = !last_q;
            if (!last_q && tx_valid) begin
              byte_d = tx_data;
              last_d = tx_last;
            end else begin
              underrun = !last_q;
              tail_d   = '0;
              state_d  = TAIL;
            end
          end
        end else begin
          smp_d = smp_q + 4'd1;
        end
      end
      TAIL: begin
        if (tail_q == tail_m1) begin
          tail_d  = '0;
          state_d = IDLE;
        end else begin
          tail_d = tail_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Output is silent in IDLE and on the edge that enters IDLE
    if (state_q == IDLE || state_d == IDLE) begin
      i_d = '0;
      q_d = '0;
    end else begin
      i_d = lut_i;
      q_d = lut_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      smp_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
      tail_q  <= '0;
      lfsr_q  <= '0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      tail_q  <= tail_d;
      lfsr_q  <= lfsr_d;
      i_q     <= i_d;
      q_q     <= q_d;
    end
  end

  assign I_out = i_q;
  assign Q_out = q_q;

endmodule

// File: tb/tb_fsk_tx_modulator.sv
// Self-checking bench for fsk_tx_modulator: packet-level reference model,
// per-cycle compare, directed literal checks and randomized packets.
module tb_fsk_tx_modulator;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        select = 2'd0;
  logic [5:0]        chan_idx = 6'd0;
  logic [7:0]        tx_data = 8'd0;
  logic              tx_valid = 1'b0;
  logic              tx_last = 1'b0;
  logic              tx_ready;
  logic signed [3:0] I_out, Q_out;
  logic              tx_on, bit_strobe, underrun;

  fsk_tx_modulator dut (
    .clk(clk), .rst(rst), .select(select), .chan_idx(chan_idx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .I_out(I_out), .Q_out(Q_out), .tx_on(tx_on),
    .bit_strobe(bit_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  localparam real PI = 3.14159265358979;

  function automatic int ref_i(input int p);
    return rnd(7.0 * $cos(2.0 * PI * p / 64.0));
  endfunction

  function automatic int ref_q(input int p);
    return rnd(7.0 * $sin(2.0 * PI * p / 64.0));
  endfunction

  // Reference model: 0 idle, 1 sending, 2 tail; m_t = cycle within byte
  int         m_st = 0, m_t = 0, m_spb = 16, m_phase = 0, m_tail = 0;
  logic [7:0] m_byte = 8'd0;
  bit         m_last = 0;
  logic [6:0] m_lfsr = 7'd0;
  int         e_i = 0, e_q = 0;

  always @(posedge clk) begin
    int ost, oph, b, stp;
    ost = m_st;
    oph = m_phase;
    if (rst) begin
      m_st = 0; m_phase = 0; m_t = 0; m_tail = 0;
    end else begin
      case (m_st)
        0: if (tx_valid) begin
          m_byte = tx_data; m_last = tx_last;
          m_spb = (select == 2'd1) ? 8 : 16;
          m_lfsr = {1'b1, chan_idx};
          m_phase = 0; m_t = 0; m_st = 1;
        end
        1: begin
          b = int'(m_byte[m_t / m_spb]);
`ifdef DATA_WHITEN_EN
          if (m_spb == 16) b = b ^ int'(m_lfsr[6]);
`endif
          stp = (m_spb == 8) ? 2 : 1;
          m_phase = (m_phase + (b != 0 ? stp : -stp) + 64) % 64;
          if (m_t % m_spb == m_spb - 1)
            m_lfsr = {m_lfsr[5], m_lfsr[4], m_lfsr[3] ^ m_lfsr[6],
                      m_lfsr[2:0], m_lfsr[6]};
          if (m_t == 8 * m_spb - 1) begin
            if (!m_last && tx_valid) begin
              m_byte = tx_data; m_last = tx_last; m_t = 0;
            end else begin
              m_st = 2; m_tail = 4 * m_spb;
            end
          end else m_t++;
        end
        default: begin
          m_tail--;
          if (m_tail == 0) m_st = 0;
        end
      endcase
    end
    if (ost == 0 || m_st == 0) begin
      e_i = 0; e_q = 0;
    end else begin
      e_i = ref_i(oph); e_q = ref_q(oph);
    end
  end

  // Per-cycle compare plus counters for directed checks
  int cnt_on = 0, cnt_bs = 0, cnt_ur = 0, cnt_rdy_on = 0;
  int cap_a = -1, cap_b = -1;
  int ca_i = 99, ca_q = 99, cb_i = 99, cb_q = 99;

  always @(negedge clk) begin
    bit bnd;
    if (chk_en) begin
      bnd = (m_st == 1) && (m_t == 8 * m_spb - 1);
      check("tx_ready", int'(tx_ready), int'(m_st == 0 || (bnd && !m_last)));
      check("tx_on", int'(tx_on), int'(m_st != 0));
      check("bit_strobe", int'(bit_strobe), int'(m_st == 1 && m_t % m_spb == 0));
      check("underrun", int'(underrun), int'(bnd && !m_last && !tx_valid));
      check("I_out", int'(I_out), e_i);
      check("Q_out", int'(Q_out), e_q);
      if (tx_on) begin
        if (cnt_on == cap_a) begin ca_i = int'(I_out); ca_q = int'(Q_out); end
        if (cnt_on == cap_b) begin cb_i = int'(I_out); cb_q = int'(Q_out); end
        cnt_on++;
        if (tx_ready) cnt_rdy_on++;
      end
      if (bit_strobe) cnt_bs++;
      if (underrun) cnt_ur++;
    end
  end

  task automatic clr(input int a, input int b);
    cnt_on = 0; cnt_bs = 0; cnt_ur = 0; cnt_rdy_on = 0;
    cap_a = a; cap_b = b;
    ca_i = 99; ca_q = 99; cb_i = 99; cb_q = 99;
  endtask

  // Entered and left at posedge+2
  task automatic send(input logic [7:0] d, input bit l, input int gap);
    bit acc;
    acc = 0;
    tx_valid = 0;
    repeat (gap) begin @(posedge clk); #2; end
    tx_data = d; tx_last = l; tx_valid = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc = tx_ready;
      @(posedge clk); #2;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 0, 1);
    tx_valid = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!tx_on) begin done = 1; break; end
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1;
    rst = 0;
    @(negedge clk);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_I", int'(I_out), 0);
    @(posedge clk); #2;

    // BLE single byte 0x01
    select = 2'd0; clr(17, 150);
    send(8'h01, 1, 0);
    wait_idle();
    check("t1_on_cycles", cnt_on, 192);
    check("t1_strobes", cnt_bs, 8);
    check("t1_I_bit1", ca_i, 0);
    check("t1_Q_bit1", ca_q, 7);
    check("t1_I_tail", cb_i, -7);
    check("t1_Q_tail", cb_q, 0);

    // 802.15.4 single byte 0xFF
    select = 2'd1; clr(5, 80);
    send(8'hFF, 1, 0);
    wait_idle();
    check("t2_on_cycles", cnt_on, 96);
    check("t2_strobes", cnt_bs, 8);
    check("t2_I_45", ca_i, 5);
    check("t2_Q_45", ca_q, 5);
    check("t2_I_tail", cb_i, 7);
    check("t2_Q_tail", cb_q, 0);

    // BLE two bytes back to back
    select = 2'd0; clr(-1, -1);
    send(8'hA5, 0, 0);
    send(8'h3C, 1, 0);
    wait_idle();
    check("t3_on_cycles", cnt_on, 320);
    check("t3_ready_pulses", cnt_rdy_on, 1);
    check("t3_strobes", cnt_bs, 16);
    check("t3_underrun", cnt_ur, 0);

    // Underrun
    clr(-1, -1);
    send(8'h5A, 0, 0);
    wait_idle();
    check("t4_on_cycles", cnt_on, 192);
    check("t4_underrun", cnt_ur, 1);

    // Reset mid-packet
    clr(-1, -1);
    send(8'h33, 1, 0);
    repeat (19) begin @(posedge clk); #2; end
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    check("t5_on", int'(tx_on), 0);
    check("t5_ready", int'(tx_ready), 1);
    check("t5_I", int'(I_out), 0);
    check("t5_Q", int'(Q_out), 0);
    @(posedge clk); #2;
    clr(17, -1);
    send(8'h01, 1, 0);
    wait_idle();
    check("t5_on_cycles", cnt_on, 192);
    check("t5_I_bit1", ca_i, 0);
    check("t5_Q_bit1", ca_q, 7);

`ifdef DATA_WHITEN_EN
    chan_idx = 6'd37;
    send(8'h00, 1, 0);
    wait_idle();
`endif

    // Randomized packets
    for (int p = 0; p < 30; p++) begin
      int nb;
      select = 2'($urandom_range(0, 3));
      chan_idx = 6'($urandom);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        int gap;
        gap = ($urandom_range(0, 5) == 0) ? $urandom_range(100, 200)
                                          : $urandom_range(0, 3);
        if (k == 0) gap = $urandom_range(0, 3);
        send(8'($urandom), k == nb - 1, gap);
        if ($urandom_range(0, 1) == 1) begin
          select = 2'($urandom_range(0, 3));
          chan_idx = 6'($urandom);
        end
      end
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
